fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Shares the single-port frame-buffer RAM between the 25 MHz display scan-out, which reads one pixel per cycle during active video, and a pixel writer such as the camera capture or the overlay path. Display reads always win. Writes are buffered in a small FIFO and drained into idle RAM cycles, which are the horizontal and vertical blanking gaps. The block sits between the VGA timing generator, the writer, and the frame-buffer RAM.

## Interface
- ADDR_W, 17, frame-buffer address width
- DATA_W, 12, pixel width (RGB444)
- FIFO_DEPTH, 4, write-buffer entries; power of two, ≥2
- clk25  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  display requests a read this cycle
- rd_addr  in  ADDR_W  display read address
- rd_valid  out  1  rd_data holds the read issued last cycle
- rd_data  out  DATA_W  read pixel
- wr_valid  in  1  writer offers a pixel
- wr_ready  out  1  FIFO can accept; a transfer happens when wr_valid && wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- ram_en  out  1  RAM access this cycle
- ram_we  out  1  access is a write
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; synchronous, valid the cycle after a read
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently buffered
- stall_count  out  16  saturating count of cycles with wr_valid && !wr_ready

## Operation
- One clock (clk25). Reset is synchronous and active-high (rst).
- Arbitration is decided combinationally each cycle from rd_req and the registered fifo_level:
  - READ when rd_req=1: ram_en=1, ram_we=0, ram_addr=rd_addr, ram_wdata=0.
  - WRITE when rd_req=0 and fifo_level>0: ram_en=1, ram_we=1, ram_addr/ram_wdata taken from the FIFO head; the head pops at the clock edge.
  - IDLE otherwise: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Reads are never delayed or dropped. Writes can be postponed indefinitely while rd_req stays high.
- FIFO:
  - Circular buffer with read pointer, write pointer and level counter. Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - wr_ready = !rst && (fifo_level < FIFO_DEPTH). It depends only on registered state, never on wr_valid or rd_req.
  - Push on wr_valid && wr_ready. Pop in WRITE cycles. A simultaneous push and pop leaves fifo_level unchanged.
  - When full, wr_ready=0 even if a pop happens in the same cycle. There is no full-bypass.
  - A pushed entry becomes poppable the next cycle. There is no empty-bypass: a push into an empty FIFO never drives the RAM in the same cycle.
  - Writes reach the RAM in acceptance order.
- No read-after-write forwarding. A read of an address still in the FIFO returns the old RAM contents.
- rd_valid is a register: next value = rd_req && !rst. rd_data = rd_valid ? ram_rdata : 0.
- stall_count increments on wr_valid && !wr_ready && !rst and holds at 16'hFFFF.
- Reset values: fifo_level=0, both pointers 0, rd_valid=0, rd_data=0, stall_count=0, wr_ready=0.
- While rst=1, ram_en=0 and ram_we=0 regardless of rd_req. FIFO contents are discarded; nothing buffered is written after reset.

## Timing
- Read latency: rd_req at cycle N produces ram_en at N (combinational) and rd_valid/rd_data at N+1.
- Write latency: a transfer accepted at cycle N reaches the RAM no earlier than N+1. This happens in the first cycle ≥N+1 with rd_req=0 once all earlier entries have drained.
- During blanking (160 idle cycles per line), a full FIFO (4 entries) drains in 4 cycles, so sustained throughput is one write per idle cycle.
- rst asserted mid-operation: the next edge clears all state. An in-flight read's rd_valid is 0 in the following cycle.

## Test plan
- Reset: hold rst 3 cycles with wr_valid=1 and rd_req=1. Required: wr_ready=0, ram_en=0, rd_valid=0 and stall_count=0 throughout; after release, fifo_level=0 and wr_ready=1.
- Reads only: rd_req=1 for 640 cycles with rd_addr=0..639, RAM preloaded with data=addr[11:0]. Required: each cycle ram_en=1, ram_we=0, ram_addr=rd_addr; rd_data one cycle later equals the address issued.
- Writes only: rd_req=0, push 5 writes (addr 100..104, data A00..A04) back to back. Required: RAM sees writes to 100..104 in order starting the cycle after the first push; fifo_level never exceeds 1; stall_count=0.
- Backpressure: rd_req=1 held, offer 6 writes. Required: 4 accepted, wr_ready=0 after the 4th, stall_count increments while wr_valid=1 and the FIFO is full, no RAM write occurs. Then drop rd_req: 4 consecutive write cycles, then wr_ready=1.
- Interleave: rd_req toggles 1,0,1,0 with 2 writes buffered. Required: writes appear only in the rd_req=0 cycles, in FIFO order, and all read data is correct.
- Saturation and mid-reset: force stall for 70000 cycles; required stall_count=FFFF. Then pulse rst with 3 entries buffered; required: stall_count=0, fifo_level=0, and no buffered write ever reaches the RAM.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares a single-port frame-buffer RAM between display scan-out reads and a
// buffered pixel writer. Display reads always take the RAM. Accepted writes
// wait in a small circular FIFO and drain into cycles with no read request.
//
// Ports
//   clk25, rst          pixel clock, synchronous active-high reset
//   rd_req/rd_addr      display read request and address (served same cycle)
//   rd_valid/rd_data    read data, one cycle after rd_req
//   wr_valid/wr_ready   writer handshake; transfer when wr_valid && wr_ready
//   wr_addr/wr_data     write address and pixel
//   ram_*               single-port RAM interface (synchronous read data)
//   fifo_level          entries currently buffered
//   stall_count         saturating count of cycles the writer was refused
//
// Handshake: wr_ready depends only on registered state (and rst), never on
// wr_valid or rd_req. A transfer occurs on any rising edge where wr_valid and
// wr_ready are both high; the writer must hold wr_addr/wr_data stable until
// that edge. A full FIFO reports wr_ready=0 even if it pops in the same cycle.
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk25,
  input  logic                        rst,
  input  logic                        rd_req,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic                        rd_valid,
  output logic [DATA_W-1:0]           rd_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 stall_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_e;

  grant_e grant;

  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             rd_valid_q, rd_valid_d;
  logic [15:0]      stall_q, stall_d;

  logic push;
  logic pop;

  assign wr_ready = !rst && (level_q < LVL_W'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (grant == GNT_WRITE);

  // Grant uses only the registered level, so an entry pushed this cycle
  // cannot reach the RAM until the next cycle.
  always_comb begin
    grant = GNT_IDLE;
    if (!rst) begin
      if (rd_req) begin
        grant = GNT_READ;
      end else if (level_q != '0) begin
        grant = GNT_WRITE;
      end
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (grant)
      GNT_READ: begin
        ram_en   = 1'b1;
        ram_addr = rd_addr;
      end
      GNT_WRITE: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = addr_mem_q[rd_ptr_q];
        ram_wdata = data_mem_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_valid_d = rd_req;
    stall_d    = stall_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      stall_q    <= stall_d;
    end
  end

  // Storage needs no reset: clearing level and pointers discards the contents.
  always_ff @(posedge clk25) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= wr_addr;
      data_mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_valid_q ? ram_rdata : '0;
  assign fifo_level  = level_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int ENT_W  = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  logic              rst = 1'b1;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [2:0]        fifo_level;
  logic [15:0]       stall_count;

  int vectors = 0;
  int errors  = 0;

  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] wlog[$];

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk25(clk25), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .fifo_level(fifo_level), .stall_count(stall_count)
  );

  // ---------------- RAM model with write log ----------------
  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always @(posedge clk25) begin
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wlog.push_back({ram_addr, ram_wdata});
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(negedge clk25);
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b1; rd_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(); settle();
      vectors++;
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready c=%0d got %b want 0", c, wr_ready); end
      vectors++;
      if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en c=%0d got %b want 0", c, ram_en); end
      vectors++;
      if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL reset_rd_valid c=%0d got %b/%h want 0/000", c, rd_valid, rd_data); end
      vectors++;
      if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall c=%0d got %h want 0000", c, stall_count); end
    end
    rst = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    cyc(); settle();
    vectors++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    vectors++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", wr_ready); end
    vectors++;
    if (wlog.size() != 0) begin errors++; $display("FAIL reset_no_write got %0d writes want 0", wlog.size()); end
  endtask

  task automatic test_reads();
    for (int i = 0; i <= 640; i++) begin
      cyc();
      if (i < 640) begin rd_req = 1'b1; rd_addr = ADDR_W'(i); end
      else         rd_req = 1'b0;
      settle();
      if (i < 640) begin
        vectors++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== ADDR_W'(i)) begin
          errors++; $display("FAIL read_issue i=%0d got en=%b we=%b addr=%0d want 1/0/%0d", i, ram_en, ram_we, ram_addr, i);
        end
      end
      if (i > 0) begin
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== DATA_W'(i - 1)) begin
          errors++; $display("FAIL read_data i=%0d got v=%b d=%h want 1/%h", i - 1, rd_valid, rd_data, DATA_W'(i - 1));
        end
      end
    end
    cyc(); settle();
    vectors++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop got %b want 0", rd_valid); end
  endtask

  task automatic test_writes_only();
    logic [ENT_W-1:0] got, want;
    wlog.delete(); exp_q.delete();
    rd_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      wr_valid = 1'b1; wr_addr = ADDR_W'(100 + k); wr_data = DATA_W'(12'hA00 + k);
      settle();
      exp_q.push_back({wr_addr, wr_data});
      vectors++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL wo_ready k=%0d got %b want 1", k, wr_ready); end
      vectors++;
      if (fifo_level > 3'd1) begin errors++; $display("FAIL wo_level k=%0d got %0d want <=1", k, fifo_level); end
      vectors++;
      if (k == 0) begin
        if (ram_en !== 1'b0) begin errors++; $display("FAIL wo_no_bypass got en=%b want 0", ram_en); end
      end else if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(99 + k) || ram_wdata !== DATA_W'(12'hA00 + k - 1)) begin
        errors++; $display("FAIL wo_write k=%0d got we=%b %0d/%h want 1 %0d/%h", k, ram_we, ram_addr, ram_wdata, 99 + k, 12'hA00 + k - 1);
      end
    end
    cyc(); wr_valid = 1'b0; settle();
    vectors++;
    if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(104) || ram_wdata !== 12'hA04) begin
      errors++; $display("FAIL wo_last got we=%b %0d/%h want 1 104/a04", ram_we, ram_addr, ram_wdata);
    end
    cyc(); settle();
    vectors++;
    if (fifo_level !== 3'd0 || ram_en !== 1'b0) begin errors++; $display("FAIL wo_drained got lvl=%0d en=%b want 0/0", fifo_level, ram_en); end
    vectors++;
    if (stall_count !== 16'd0) begin errors++; $display("FAIL wo_stall got %h want 0000", stall_count); end
    vectors++;
    if (wlog.size() != 5) begin errors++; $display("FAIL wo_count got %0d want 5", wlog.size()); end
    while (exp_q.size() > 0 && wlog.size() > 0) begin
      want = exp_q.pop_front(); got = wlog.pop_front();
      vectors++;
      if (got !== want) begin errors++; $display("FAIL wo_order got %h want %h", got, want); end
    end
    exp_q.delete(); wlog.delete();
  endtask

  task automatic test_backpressure();
    int acc;
    logic [ENT_W-1:0] got, want;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      rd_req = 1'b1; rd_addr = '0;
      wr_valid = 1'b1; wr_addr = ADDR_W'(200 + acc); wr_data = DATA_W'(12'hB00 + acc);
      settle();
      vectors++;
      if (wr_ready !== (c < 4)) begin errors++; $display("FAIL bp_ready c=%0d got %b want %b", c, wr_ready, c < 4); end
      vectors++;
      if (ram_we !== 1'b0 || ram_en !== 1'b1) begin errors++; $display("FAIL bp_no_write c=%0d got en=%b we=%b want 1/0", c, ram_en, ram_we); end
      vectors++;
      if (stall_count !== 16'((c > 4) ? c - 4 : 0)) begin
        errors++; $display("FAIL bp_stall c=%0d got %0d want %0d", c, stall_count, (c > 4) ? c - 4 : 0);
      end
      if (c < 4) begin exp_q.push_back({wr_addr, wr_data}); acc++; end
    end
    cyc(); wr_valid = 1'b0; settle();
    vectors++;
    if (stall_count !== 16'd2 || fifo_level !== 3'd4) begin
      errors++; $display("FAIL bp_hold got stall=%0d lvl=%0d want 2/4", stall_count, fifo_level);
    end
    for (int j = 0; j < 4; j++) begin
      cyc(); rd_req = 1'b0; settle();
      vectors++;
      if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(200 + j) || ram_wdata !== DATA_W'(12'hB00 + j)) begin
        errors++; $display("FAIL bp_drain j=%0d got we=%b %0d/%h want 1 %0d/%h", j, ram_we, ram_addr, ram_wdata, 200 + j, 12'hB00 + j);
      end
      vectors++;
      if (wr_ready !== (j > 0)) begin errors++; $display("FAIL bp_drain_ready j=%0d got %b want %b", j, wr_ready, j > 0); end
    end
    cyc(); settle();
    vectors++;
    if (ram_en !== 1'b0 || wr_ready !== 1'b1 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL bp_done got en=%b rdy=%b lvl=%0d want 0/1/0", ram_en, wr_ready, fifo_level);
    end
    vectors++;
    if (wlog.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", wlog.size()); end
    while (exp_q.size() > 0 && wlog.size() > 0) begin
      want = exp_q.pop_front(); got = wlog.pop_front();
      vectors++;
      if (got !== want) begin errors++; $display("FAIL bp_order got %h want %h", got, want); end
    end
    exp_q.delete(); wlog.delete();
  endtask

  task automatic test_interleave();
    // Per cycle: rd_req, rd_addr, push?, expected write address (0 = none).
    logic       req_t  [7] = '{1, 1, 1, 0, 1, 0, 0};
    int         addr_t [7] = '{10, 11, 12, 0, 13, 0, 0};
    logic       push_t [7] = '{1, 1, 0, 0, 0, 0, 0};
    int         wexp_t [7] = '{0, 0, 0, 300, 0, 301, 0};
    int         prev_rd;
    prev_rd = -1;
    for (int c = 0; c < 7; c++) begin
      cyc();
      rd_req = req_t[c]; rd_addr = ADDR_W'(addr_t[c]);
      wr_valid = push_t[c]; wr_addr = ADDR_W'(300 + c); wr_data = DATA_W'(12'hC00 + c);
      settle();
      vectors++;
      if (req_t[c]) begin
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== ADDR_W'(addr_t[c])) begin
          errors++; $display("FAIL il_read c=%0d got en=%b we=%b addr=%0d want 1/0/%0d", c, ram_en, ram_we, ram_addr, addr_t[c]);
        end
      end else if (wexp_t[c] != 0) begin
        if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(wexp_t[c]) || ram_wdata !== DATA_W'(12'hC00 + wexp_t[c] - 300)) begin
          errors++; $display("FAIL il_write c=%0d got we=%b %0d/%h want 1 %0d", c, ram_we, ram_addr, ram_wdata, wexp_t[c]);
        end
      end else if (ram_en !== 1'b0) begin
        errors++; $display("FAIL il_idle c=%0d got en=%b want 0", c, ram_en);
      end
      vectors++;
      if (prev_rd >= 0) begin
        if (rd_valid !== 1'b1 || rd_data !== DATA_W'(prev_rd)) begin
          errors++; $display("FAIL il_rdata c=%0d got v=%b d=%h want 1/%h", c, rd_valid, rd_data, DATA_W'(prev_rd));
        end
      end else if (rd_valid !== 1'b0) begin
        errors++; $display("FAIL il_rvalid c=%0d got %b want 0", c, rd_valid);
      end
      prev_rd = req_t[c] ? addr_t[c] : -1;
    end
    vectors++;
    if (wlog.size() != 2) begin errors++; $display("FAIL il_count got %0d want 2", wlog.size()); end
    wr_valid = 1'b0;
    wlog.delete();
  endtask

  task automatic test_saturation_reset();
    logic [ENT_W-1:0] got, want;
    for (int c = 0; c < 4; c++) begin
      cyc();
      rd_req = 1'b1; rd_addr = '0;
      wr_valid = 1'b1; wr_addr = ADDR_W'(400 + c); wr_data = DATA_W'(12'hD00 + c);
      settle();
      if (c == 0) exp_q.push_back({wr_addr, wr_data});
    end
    wr_addr = ADDR_W'(404); wr_data = 12'hD04;
    for (int c = 0; c < 70000; c++) cyc();
    settle();
    vectors++;
    if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_stall got %h want ffff", stall_count); end
    // One idle-for-reads cycle drains the oldest entry, leaving three.
    cyc(); wr_valid = 1'b0; rd_req = 1'b0; settle();
    vectors++;
    if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(400)) begin errors++; $display("FAIL sat_pop got we=%b addr=%0d want 1/400", ram_we, ram_addr); end
    cyc(); rd_req = 1'b1; settle();
    vectors++;
    if (fifo_level !== 3'd3) begin errors++; $display("FAIL sat_level got %0d want 3", fifo_level); end
    cyc(); rst = 1'b1; settle();
    vectors++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL mid_rst_ram got en=%b we=%b want 0/0", ram_en, ram_we); end
    cyc(); rst = 1'b0; rd_req = 1'b0; settle();
    vectors++;
    if (stall_count !== 16'd0 || fifo_level !== 3'd0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_clear got stall=%h lvl=%0d v=%b want 0000/0/0", stall_count, fifo_level, rd_valid);
    end
    for (int c = 0; c < 4; c++) begin
      cyc(); settle();
      vectors++;
      if (ram_en !== 1'b0) begin errors++; $display("FAIL mid_rst_no_write c=%0d got en=%b want 0", c, ram_en); end
    end
    vectors++;
    if (wlog.size() != 1) begin errors++; $display("FAIL mid_rst_count got %0d want 1", wlog.size()); end
    while (exp_q.size() > 0 && wlog.size() > 0) begin
      want = exp_q.pop_front(); got = wlog.pop_front();
      vectors++;
      if (got !== want) begin errors++; $display("FAIL mid_rst_order got %h want %h", got, want); end
    end
    exp_q.delete(); wlog.delete();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 640; i++) mem[i] = DATA_W'(i);
    test_reset();
    test_reads();
    test_writes_only();
    test_backpressure();
    test_interleave();
    test_saturation_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
